// File: rtl/ikaopm_noise_multi.sv
// ikaopm_noise_multi
// Multi-channel noise source. Each channel has a frequency divider, a 17-bit
// LFSR that can fold down to a 7-bit sub-LFSR (short mode), and a signed
// output scaled by its attenuation. Channels share only the clock, the reset
// and the clock enable. Channel 0's LFSR bit 0 also drives the LFO noise bit.
module ikaopm_noise_multi #(
    parameter int NCH       = 1,
    parameter int FRQ_W     = 5,
    parameter int LFSR_W    = 17,
    parameter int TAP       = 3,
    parameter int SHORT_W   = 7,
    parameter int SHORT_TAP = 1,
    parameter int ATT_W     = 10,
    parameter int OUT_W     = 14
) (
    input  logic                   i_EMUCLK,
    input  logic                   i_MRST,
    input  logic                   i_CEN_n,
    input  logic [NCH*FRQ_W-1:0]   i_NFRQ,
    input  logic [NCH-1:0]         i_MODE,
    input  logic [NCH*ATT_W-1:0]   i_ATTEN,
    output logic [NCH-1:0]         o_TICK,
    output logic [NCH*OUT_W-1:0]   o_NOISE,
    output logic                   o_LFO_NOISE
);

    // Left-justify the inverted attenuation just below the sign bit.
    localparam int MAG_SHIFT = OUT_W - 1 - ATT_W;

    genvar k;
    generate
        for (k = 0; k < NCH; k++) begin : g_ch
            logic [FRQ_W-1:0]  w_nfrq;
            logic [ATT_W-1:0]  w_atten;
            logic [ATT_W-1:0]  w_atten_inv;
            logic              w_mode;
            logic              w_term;
            logic              w_long_zero;
            logic              w_short_zero;
            logic              w_fb;
            logic              w_sfb;
            logic [LFSR_W-1:0] w_lfsr_nxt;
            logic [OUT_W-1:0]  w_mag;
            logic [OUT_W-1:0]  w_noise_nxt;

            logic [FRQ_W-1:0]  r_cnt;
            logic              r_tick;
            logic [LFSR_W-1:0] r_lfsr;
            logic              r_sign;
            logic [OUT_W-1:0]  r_noise;

            assign w_nfrq      = i_NFRQ[k*FRQ_W +: FRQ_W];
            assign w_atten     = i_ATTEN[k*ATT_W +: ATT_W];
            assign w_mode      = i_MODE[k];
            assign w_atten_inv = ~w_atten;

            // Terminal count is equality only, so a code change that leaves the
            // counter above the new terminal value just wraps around first.
            assign w_term       = (r_cnt == ~w_nfrq);
            assign w_long_zero  = (r_lfsr == '0);
            assign w_short_zero = (r_lfsr[SHORT_W-1:0] == '0);

            // Divider: count up every step, reload and emit a one-step tick at terminal count.
            always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
                if (i_MRST) begin
                    r_cnt  <= '0;
                    r_tick <= 1'b0;
                end else if (!i_CEN_n) begin
                    if (w_term) begin
                        r_cnt  <= '0;
                        r_tick <= 1'b1;
                    end else begin
                        r_cnt  <= r_cnt + 1'b1;
                        r_tick <= 1'b0;
                    end
                end
            end

            // Next LFSR value; an all-zero active field is kicked out by forcing ones in.
            always_comb begin
                w_fb  = r_lfsr[0] ^ r_lfsr[TAP];
                w_sfb = r_lfsr[0] ^ r_lfsr[SHORT_TAP];
                if (w_mode ? w_short_zero : w_long_zero) begin
                    w_fb  = 1'b1;
                    w_sfb = 1'b1;
                end
                w_lfsr_nxt = {w_fb, r_lfsr[LFSR_W-1:1]};
                if (w_mode) begin
                    w_lfsr_nxt[SHORT_W-1] = w_sfb;
                end
            end

            // LFSR and sign advance on the step after the divider's terminal count.
            always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
                if (i_MRST) begin
                    r_lfsr <= '0;
                    r_sign <= 1'b0;
                end else if (!i_CEN_n && r_tick) begin
                    r_lfsr <= w_lfsr_nxt;
                    r_sign <= r_lfsr[0];
                end
            end

            assign w_mag       = {{(OUT_W-ATT_W){1'b0}}, w_atten_inv} << MAG_SHIFT;
            assign w_noise_nxt = (&w_atten) ? '0 : (r_sign ? -w_mag : w_mag);

            // Output sample registered every step from the current sign and attenuation.
            always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
                if (i_MRST) begin
                    r_noise <= '0;
                end else if (!i_CEN_n) begin
                    r_noise <= w_noise_nxt;
                end
            end

            assign o_TICK[k]                = r_tick;
            assign o_NOISE[k*OUT_W +: OUT_W] = r_noise;

            if (k == 0) begin : g_lfo
                assign o_LFO_NOISE = r_lfsr[0];
            end
        end
    endgenerate

endmodule

// File: tb/tb_ikaopm_noise_multi.sv
// Directed bench for ikaopm_noise_multi with two channels.
module tb_ikaopm_noise_multi;

    localparam int NCH   = 2;
    localparam int FRQ_W = 5;
    localparam int ATT_W = 10;
    localparam int OUT_W = 14;

    logic                 clk   = 1'b0;
    logic                 rst   = 1'b1;
    logic                 cen_n = 1'b1;
    logic [NCH*FRQ_W-1:0] nfrq  = '0;
    logic [NCH-1:0]       mode  = '0;
    logic [NCH*ATT_W-1:0] atten = '0;
    logic [NCH-1:0]       tick;
    logic [NCH*OUT_W-1:0] noise;
    logic                 lfo;

    int n_checks = 0;
    int n_fail   = 0;

    bit lfo_bits [300];

    always #5 clk = ~clk;

    ikaopm_noise_multi #(.NCH(NCH)) dut (
        .i_EMUCLK   (clk),
        .i_MRST     (rst),
        .i_CEN_n    (cen_n),
        .i_NFRQ     (nfrq),
        .i_MODE     (mode),
        .i_ATTEN    (atten),
        .o_TICK     (tick),
        .o_NOISE    (noise),
        .o_LFO_NOISE(lfo)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] noise0();
        return 32'(noise[OUT_W-1:0]);
    endfunction

    function automatic logic [31:0] noise1();
        return 32'(noise[2*OUT_W-1:OUT_W]);
    endfunction

    initial begin
        logic [31:0] exp_n0;
        int ones, mism, zero_win;

        // ---------------- long mode, ch0 NFRQ=31, ch1 NFRQ=0 ----------------
        nfrq  = {5'd0, 5'd31};
        mode  = 2'b00;
        atten = {10'h155, 10'h000};
        cen_n = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_tick",   32'(tick), 32'h0);
        check("rst_noise0", noise0(), 32'h0);
        check("rst_noise1", noise1(), 32'h0);
        check("rst_lfo",    32'(lfo), 32'h0);
        rst = 1'b0;

        for (int n = 1; n <= 64; n++) begin
            atten[ATT_W-1:0] = (n == 10) ? 10'h200 : (n == 11) ? 10'h3FF : 10'h000;
            step();
            check($sformatf("tick0_n%0d", n), 32'(tick[0]), 32'h1);
            check($sformatf("tick1_n%0d", n), 32'(tick[1]), 32'((n % 32) == 0));
            check($sformatf("noise1_n%0d", n), noise1(), 32'h1550);
            if (n <= 22) begin
                exp_n0 = (n == 10) ? 32'h0FF8 :
                         (n == 11) ? 32'h0000 :
                         (n == 20) ? 32'h2008 : 32'h1FF8;
                check($sformatf("lfo_n%0d", n), 32'(lfo), 32'(n == 18));
                check($sformatf("noise0_n%0d", n), noise0(), exp_n0);
            end
            if (n == 18) begin
                cen_n = 1'b1;
                repeat (3) @(negedge clk);
                check("hold_lfo",    32'(lfo), 32'h1);
                check("hold_tick",   32'(tick), 32'h1);
                check("hold_noise0", noise0(), 32'h1FF8);
                cen_n = 1'b0;
            end
        end

        // ---------------- asynchronous reset with no clock edge ----------------
        cen_n = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("arst_tick",   32'(tick), 32'h0);
        check("arst_noise0", noise0(), 32'h0);
        check("arst_noise1", noise1(), 32'h0);
        check("arst_lfo",    32'(lfo), 32'h0);

        // ---------------- NFRQ change leaves cnt above terminal ----------------
        @(negedge clk);
        nfrq  = {5'd0, 5'd0};
        cen_n = 1'b0;
        rst   = 1'b0;
        check("chg_tick_start", 32'(tick[0]), 32'h0);
        for (int n = 1; n <= 20; n++) begin
            step();
            check($sformatf("chg_pre_n%0d", n), 32'(tick[0]), 32'h0);
        end
        nfrq[FRQ_W-1:0] = 5'd31;
        for (int n = 1; n <= 12; n++) begin
            step();
            check($sformatf("chg_wrap_n%0d", n), 32'(tick[0]), 32'h0);
        end
        step();
        check("chg_first_tick", 32'(tick[0]), 32'h1);
        step();
        check("chg_second_tick", 32'(tick[0]), 32'h1);

        // ---------------- short mode on ch0 ----------------
        rst  = 1'b1;
        mode = 2'b01;
        nfrq = {5'd0, 5'd31};
        @(negedge clk);
        rst = 1'b0;
        step();
        for (int j = 0; j < 300; j++) begin
            step();
            lfo_bits[j] = lfo;
        end
        for (int j = 0; j < 6; j++) begin
            check($sformatf("short_head_%0d", j), 32'(lfo_bits[j]), 32'h0);
        end
        check("short_head_6", 32'(lfo_bits[6]), 32'h1);
        ones = 0;
        mism = 0;
        for (int j = 0; j < 127; j++) begin
            if (lfo_bits[j]) ones++;
            if (lfo_bits[j] != lfo_bits[j+127]) mism++;
        end
        zero_win = 0;
        for (int j = 0; j + 7 <= 300; j++) begin
            if (lfo_bits[j] == 0 && lfo_bits[j+1] == 0 && lfo_bits[j+2] == 0 &&
                lfo_bits[j+3] == 0 && lfo_bits[j+4] == 0 && lfo_bits[j+5] == 0 &&
                lfo_bits[j+6] == 0) zero_win++;
        end
        check("short_ones_per_period", 32'(ones), 32'd64);
        check("short_period_127",      32'(mism), 32'd0);
        check("short_no_zero_state",   32'(zero_win), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
